irq_tick_ctrl: RTL

Interrupt controller and system tick generator for the MMU09 board. Latches, masks and prioritises the UART, CH375 and real-time-clock interrupt lines plus an internal periodic tick. Routes each source to the 6809 IRQ or FIRQ line under kernel control. Decode logic selects it through a 4-byte register window in the kernel I/O area; it replaces the direct UART→IRQ and CH375→FIRQ wiring.

---
 rtl/irq_tick_ctrl_if.sv | 19 +
 rtl/irq_tick_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/irq_tick_ctrl_if.sv
// CPU register-window bus for irq_tick_ctrl: select, direction, offset and data.
interface irq_tick_ctrl_if;
  logic       i_sel;
  logic       i_rw;
  logic [1:0] i_addr;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       o_data_oe;

  modport master (
    output i_sel, i_rw, i_addr, i_data,
    input  o_data, o_data_oe
  );

  modport slave (
    input  i_sel, i_rw, i_addr, i_data,
    output o_data, o_data_oe
  );
endinterface

// File: rtl/irq_tick_ctrl.sv
// MMU09 interrupt controller: latches/masks/prioritises tick, UART, CH375 and RTC
// sources and routes each to the 6809 IRQ or FIRQ line.
module irq_tick_ctrl #(
  parameter int unsigned TICK_DIV = 40000
) (
  input  logic           i_eclk,
  input  logic           i_reset,
  irq_tick_ctrl_if.slave bus,
  input  logic           i_uartirq,
  input  logic           i_chirq,
  input  logic           i_rtcirq,
  output logic           irq_n,
  output logic           firq_n
);

  localparam int unsigned CNT_W = 20;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_ENABLE = 2'd1;
  localparam logic [1:0] A_ROUTE  = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  logic [1:0]       uart_sync, ch_sync, rtc_sync;
  logic             rtc_prev;
  logic             pend0, pend3, ovr;
  logic [3:0]       enable, route;
  logic             tick_en;
  logic [CNT_W-1:0] cnt;

  logic             wr_en, wr_status, wr_enable, wr_route, wr_ctrl;
  logic             tick_exp, rtc_fall, reload;
  logic [3:0]       pend, act;
  logic [2:0]       id;
  logic             unused_wdata;

  assign wr_en     = bus.i_sel & ~bus.i_rw;
  assign wr_status = wr_en && (bus.i_addr == A_STATUS);
  assign wr_enable = wr_en && (bus.i_addr == A_ENABLE);
  assign wr_route  = wr_en && (bus.i_addr == A_ROUTE);
  assign wr_ctrl   = wr_en && (bus.i_addr == A_CTRL);

  assign tick_exp  = tick_en && (cnt == '0);
  assign reload    = tick_exp || (wr_ctrl && bus.i_data[1]);
  assign rtc_fall  = rtc_prev & ~rtc_sync[1];

  // Level sources are live from the synchronisers; edge sources are sticky.
  assign pend = {pend3, ~ch_sync[1], ~uart_sync[1], pend0};
  assign act  = pend & enable;

  assign unused_wdata = ^bus.i_data[6:4];

  // Priority: CH375 > UART > tick > RTC; id is 1 + source index.
  always_comb begin
    id = 3'd0;
    if (act[2])      id = 3'd3;
    else if (act[1]) id = 3'd2;
    else if (act[0]) id = 3'd1;
    else if (act[3]) id = 3'd4;
  end

  always_comb begin
    bus.o_data = 8'h00;
    case (bus.i_addr)
      A_STATUS: bus.o_data = {ovr, 3'b000, pend};
      A_ENABLE: bus.o_data = {4'b0000, enable};
      A_ROUTE:  bus.o_data = {4'b0000, route};
      A_CTRL:   bus.o_data = {1'b0, id, 3'b000, tick_en};
      default:  bus.o_data = 8'h00;
    endcase
  end

  assign bus.o_data_oe = bus.i_sel & bus.i_rw;

  // Input synchronisers, idle-high.
  always_ff @(posedge i_eclk or negedge i_reset) begin
    if (!i_reset) begin
      uart_sync <= 2'b11;
      ch_sync   <= 2'b11;
      rtc_sync  <= 2'b11;
      rtc_prev  <= 1'b1;
    end else begin
      uart_sync <= {uart_sync[0], i_uartirq};
      ch_sync   <= {ch_sync[0], i_chirq};
      rtc_sync  <= {rtc_sync[0], i_rtcirq};
      rtc_prev  <= rtc_sync[1];
    end
  end

  // Tick counter: reload on expiry or strobe, else count while enabled.
  always_ff @(posedge i_eclk or negedge i_reset) begin
    if (!i_reset) begin
      cnt <= RELOAD;
    end else if (reload) begin
      cnt <= RELOAD;
    end else if (tick_en) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Sticky bits: a set event wins over a same-cycle clear.
  always_ff @(posedge i_eclk or negedge i_reset) begin
    if (!i_reset) begin
      pend0 <= 1'b0;
      pend3 <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      pend0 <= tick_exp | (pend0 & ~(wr_status & bus.i_data[0]));
      pend3 <= rtc_fall | (pend3 & ~(wr_status & bus.i_data[3]));
      ovr   <= (tick_exp & pend0) | (ovr & ~(wr_status & bus.i_data[7]));
    end
  end

  always_ff @(posedge i_eclk or negedge i_reset) begin
    if (!i_reset) begin
      enable  <= 4'h0;
      route   <= 4'h0;
      tick_en <= 1'b0;
    end else begin
      if (wr_enable) enable  <= bus.i_data[3:0];
      if (wr_route)  route   <= bus.i_data[3:0];
      if (wr_ctrl)   tick_en <= bus.i_data[0];
    end
  end

  always_ff @(posedge i_eclk or negedge i_reset) begin
    if (!i_reset) begin
      irq_n  <= 1'b1;
      firq_n <= 1'b1;
    end else begin
      irq_n  <= ~|(act & ~route);
      firq_n <= ~|(act & route);
    end
  end

endmodule
